// File: rtl/regfile_mp.sv
// regfile_mp: register file with two byte-masked write ports and a
// configurable number of independent read ports. Optional same-cycle write
// forwarding, registered reads and a hardwired-zero entry 0.
module regfile_mp #(
  parameter int NUM_ADDR_BITS = 6,
  parameter int REG_WIDTH     = 32,
  parameter int NUM_RD_PORTS  = 2,
  parameter int READ_LATENCY  = 0,
  parameter int BYPASS        = 1,
  parameter int ZERO_REG      = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [1:0]                             writeEnable,
  input  logic [2*NUM_ADDR_BITS-1:0]             wrAddr,
  input  logic [2*REG_WIDTH-1:0]                 wrData,
  input  logic [2*(REG_WIDTH/8)-1:0]             wrByteEn,
  input  logic [NUM_RD_PORTS*NUM_ADDR_BITS-1:0]  rdAddr,
  output logic [NUM_RD_PORTS*REG_WIDTH-1:0]      rdData,
  output logic                                   wrCollision
);

  localparam int DEPTH     = 2 ** NUM_ADDR_BITS;
  localparam int NUM_BYTES = REG_WIDTH / 8;

  logic [REG_WIDTH-1:0]     mem      [DEPTH];
  logic [NUM_ADDR_BITS-1:0] waddr    [2];
  logic [REG_WIDTH-1:0]     wdata    [2];
  logic [NUM_BYTES-1:0]     wbe      [2];
  logic [1:0]               wen;
  logic [NUM_ADDR_BITS-1:0] raddr    [NUM_RD_PORTS];
  logic [REG_WIDTH-1:0]     rd_value [NUM_RD_PORTS];
  logic                     collision;

  // Unpack write ports; a write aimed at the hardwired zero entry is dropped
  // here so it neither updates storage, forwards, nor counts as a collision.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      waddr[i] = wrAddr[i*NUM_ADDR_BITS +: NUM_ADDR_BITS];
      wdata[i] = wrData[i*REG_WIDTH +: REG_WIDTH];
      wbe[i]   = wrByteEn[i*NUM_BYTES +: NUM_BYTES];
      wen[i]   = writeEnable[i] && !((ZERO_REG != 0) && (waddr[i] == '0));
    end
  end

  assign collision = wen[0] && wen[1] && (waddr[0] == waddr[1]);

  // Byte-masked storage update; port 1 is issued last so it wins shared bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        for (int b = 0; b < NUM_BYTES; b++)
          if (wen[i] && wbe[i][b]) mem[waddr[i]][b*8 +: 8] <= wdata[i][b*8 +: 8];
    end
  end

  // Flag a dual write to one address for exactly the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrCollision <= 1'b0;
    else        wrCollision <= collision;
  end

  // Per read port value: stored entry, overlaid with this cycle's enabled
  // write bytes when forwarding is on (port 1 applied last, as in storage).
  always_comb begin
    for (int j = 0; j < NUM_RD_PORTS; j++) begin
      raddr[j]    = rdAddr[j*NUM_ADDR_BITS +: NUM_ADDR_BITS];
      rd_value[j] = mem[raddr[j]];
      if (BYPASS != 0) begin
        for (int i = 0; i < 2; i++)
          for (int b = 0; b < NUM_BYTES; b++)
            if (wen[i] && wbe[i][b] && (waddr[i] == raddr[j]))
              rd_value[j][b*8 +: 8] = wdata[i][b*8 +: 8];
      end
      if ((ZERO_REG != 0) && (raddr[j] == '0)) rd_value[j] = '0;
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      // Combinational read ports.
      always_comb begin
        for (int j = 0; j < NUM_RD_PORTS; j++)
          rdData[j*REG_WIDTH +: REG_WIDTH] = rd_value[j];
      end
    end else begin : g_reg_read
      // Registered read ports, cleared immediately by reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdData <= '0;
        end else begin
          for (int j = 0; j < NUM_RD_PORTS; j++)
            rdData[j*REG_WIDTH +: REG_WIDTH] <= rd_value[j];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed, table-driven bench for regfile_mp. Four instances
// share one stimulus: default, no-forwarding, zero-register, registered-read.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  write_enable = '0;
  logic [11:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_be = '0;
  logic [11:0] rd_addr = '0;

  logic [63:0] rd_main, rd_nb, rd_z, rd_l1;
  logic        coll_main, coll_nb, coll_z, coll_l1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  we;
    logic [5:0]  a0;
    logic [31:0] d0;
    logic [3:0]  be0;
    logic [5:0]  a1;
    logic [31:0] d1;
    logic [3:0]  be1;
    logic [5:0]  ra0;
    logic [5:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic        exp_coll;
  } vec_t;

  vec_t vecs [13];

  regfile_mp dut_main (
    .clk(clk), .rst_n(rst_n), .writeEnable(write_enable), .wrAddr(wr_addr),
    .wrData(wr_data), .wrByteEn(wr_be), .rdAddr(rd_addr),
    .rdData(rd_main), .wrCollision(coll_main));

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .writeEnable(write_enable), .wrAddr(wr_addr),
    .wrData(wr_data), .wrByteEn(wr_be), .rdAddr(rd_addr),
    .rdData(rd_nb), .wrCollision(coll_nb));

  regfile_mp #(.ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .writeEnable(write_enable), .wrAddr(wr_addr),
    .wrData(wr_data), .wrByteEn(wr_be), .rdAddr(rd_addr),
    .rdData(rd_z), .wrCollision(coll_z));

  regfile_mp #(.READ_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .writeEnable(write_enable), .wrAddr(wr_addr),
    .wrData(wr_data), .wrByteEn(wr_be), .rdAddr(rd_addr),
    .rdData(rd_l1), .wrCollision(coll_l1));

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic applyStimulus(input vec_t v);
    write_enable = v.we;
    wr_addr      = {v.a1, v.a0};
    wr_data      = {v.d1, v.d0};
    wr_be        = {v.be1, v.be0};
    rd_addr      = {v.ra1, v.ra0};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // we, a0, d0, be0, a1, d1, be1, ra0, ra1, exp0, exp1, exp_coll
    vecs[0]  = '{2'b01, 6'h01, 32'h14578BB0, 4'hF, 6'h00, 32'h0, 4'h0, 6'h01, 6'h05, 32'h14578BB0, 32'h00000000, 1'b0};
    vecs[1]  = '{2'b00, 6'h00, 32'h0, 4'h0, 6'h00, 32'h0, 4'h0, 6'h01, 6'h00, 32'h14578BB0, 32'h00000000, 1'b0};
    vecs[2]  = '{2'b01, 6'h01, 32'hFFFFFFFF, 4'h3, 6'h00, 32'h0, 4'h0, 6'h01, 6'h02, 32'h1457FFFF, 32'h00000000, 1'b0};
    vecs[3]  = '{2'b00, 6'h00, 32'h0, 4'h0, 6'h00, 32'h0, 4'h0, 6'h01, 6'h01, 32'h1457FFFF, 32'h1457FFFF, 1'b0};
    vecs[4]  = '{2'b11, 6'h3F, 32'hAAAAAAAA, 4'hF, 6'h3F, 32'h55555555, 4'h5, 6'h3F, 6'h01, 32'hAA55AA55, 32'h1457FFFF, 1'b0};
    vecs[5]  = '{2'b00, 6'h00, 32'h0, 4'h0, 6'h00, 32'h0, 4'h0, 6'h3F, 6'h3F, 32'hAA55AA55, 32'hAA55AA55, 1'b1};
    vecs[6]  = '{2'b00, 6'h00, 32'h0, 4'h0, 6'h00, 32'h0, 4'h0, 6'h00, 6'h3F, 32'h00000000, 32'hAA55AA55, 1'b0};
    vecs[7]  = '{2'b10, 6'h00, 32'h0, 4'h0, 6'h02, 32'hDDDDDDDD, 4'hF, 6'h00, 6'h02, 32'h00000000, 32'hDDDDDDDD, 1'b0};
    vecs[8]  = '{2'b11, 6'h05, 32'h12345678, 4'hC, 6'h06, 32'hCAFEBABE, 4'h1, 6'h05, 6'h06, 32'h12340000, 32'h000000BE, 1'b0};
    vecs[9]  = '{2'b11, 6'h07, 32'h11111111, 4'h0, 6'h07, 32'h22222222, 4'h0, 6'h07, 6'h05, 32'h00000000, 32'h12340000, 1'b0};
    vecs[10] = '{2'b00, 6'h00, 32'h0, 4'h0, 6'h00, 32'h0, 4'h0, 6'h07, 6'h06, 32'h00000000, 32'h000000BE, 1'b1};
    vecs[11] = '{2'b01, 6'h3F, 32'h00000000, 4'h6, 6'h00, 32'h0, 4'h0, 6'h3F, 6'h3F, 32'hAA000055, 32'hAA000055, 1'b0};
    vecs[12] = '{2'b00, 6'h00, 32'h0, 4'h0, 6'h00, 32'h0, 4'h0, 6'h3F, 6'h02, 32'hAA000055, 32'hDDDDDDDD, 1'b0};

    // Reset and the all-zero state of every entry.
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset coll", {31'd0, coll_main}, 32'd0);
    checkOutput("reset l1 rd", rd_l1[31:0], 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      rd_addr = {6'(2*k+1), 6'(2*k)};
      #1;
      checkOutput($sformatf("reset addr %0d", 2*k), rd_main[31:0], 32'd0);
      checkOutput($sformatf("reset addr %0d", 2*k+1), rd_main[63:32], 32'd0);
    end
    nextCycle();

    // Main table on the default instance.
    for (int k = 0; k < 13; k++) begin
      applyStimulus(vecs[k]);
      @(negedge clk);
      checkOutput($sformatf("v%0d rd0", k), rd_main[31:0], vecs[k].exp0);
      checkOutput($sformatf("v%0d rd1", k), rd_main[63:32], vecs[k].exp1);
      checkOutput($sformatf("v%0d coll", k), {31'd0, coll_main}, {31'd0, vecs[k].exp_coll});
      nextCycle();
    end

    // Forwarding versus no forwarding, and registered read capture.
    write_enable = 2'b01; wr_addr = {6'h00, 6'h02}; wr_data = {32'h0, 32'h99999999};
    wr_be = 8'h0F; rd_addr = {6'h02, 6'h02};
    @(negedge clk);
    checkOutput("bypass on", rd_main[63:32], 32'h99999999);
    checkOutput("bypass off", rd_nb[63:32], 32'hDDDDDDDD);
    nextCycle();
    write_enable = 2'b00;
    #1;
    checkOutput("nb after write", rd_nb[63:32], 32'h99999999);
    checkOutput("l1 captured post-write", rd_l1[63:32], 32'h99999999);

    // Hardwired zero entry.
    nextCycle();
    write_enable = 2'b11; wr_addr = {6'h00, 6'h00};
    wr_data = {32'h88888888, 32'h88888888}; wr_be = 8'hFF; rd_addr = {6'h00, 6'h00};
    #1;
    checkOutput("zero rd0 bypass", rd_z[31:0], 32'd0);
    checkOutput("zero rd1 bypass", rd_z[63:32], 32'd0);
    checkOutput("nonzero addr0 bypass", rd_main[31:0], 32'h88888888);
    nextCycle();
    write_enable = 2'b00;
    #1;
    checkOutput("zero rd0 stored", rd_z[31:0], 32'd0);
    checkOutput("zero coll", {31'd0, coll_z}, 32'd0);
    checkOutput("nonzero coll", {31'd0, coll_main}, 32'd1);
    checkOutput("nonzero addr0 stored", rd_main[31:0], 32'h88888888);

    // Registered read latency.
    rd_addr = {6'h3F, 6'h06};
    nextCycle();
    checkOutput("l1 addr6", rd_l1[31:0], 32'h000000BE);
    rd_addr = {6'h3F, 6'h05};
    #1;
    checkOutput("l1 holds", rd_l1[31:0], 32'h000000BE);
    nextCycle();
    checkOutput("l1 addr5", rd_l1[31:0], 32'h12340000);

    // Mid-cycle asynchronous reset, with a write attempted while held.
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async l1 rd0", rd_l1[31:0], 32'd0);
    checkOutput("async l1 rd1", rd_l1[63:32], 32'd0);
    checkOutput("async lost addr5", rd_main[31:0], 32'd0);
    checkOutput("async lost addr3F", rd_main[63:32], 32'd0);
    write_enable = 2'b01; wr_addr = {6'h00, 6'h09}; wr_data = {32'h0, 32'hFFFFFFFF}; wr_be = 8'h0F;
    nextCycle();
    rst_n = 1'b1;
    write_enable = 2'b00; rd_addr = {6'h00, 6'h09};
    #1;
    checkOutput("write in reset ignored", rd_main[31:0], 32'd0);

    // Normal operation after reset release.
    nextCycle();
    write_enable = 2'b01; wr_data = {32'h0, 32'h0BADF00D};
    nextCycle();
    write_enable = 2'b00;
    #1;
    checkOutput("resume write", rd_main[31:0], 32'h0BADF00D);
    checkOutput("resume l1", rd_l1[31:0], 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter NUM_ADDR_BITS, default 6: address width; depth = 2**NUM_ADDR_BITS entries.
REQ-002 SHALL have parameter REG_WIDTH, default 32: entry width in bits; must be a multiple of 8.
REQ-003 SHALL have parameter NUM_RD_PORTS, default 2: number of independent read ports, range 1..8.
REQ-004 SHALL have parameter READ_LATENCY, default 0: 0 = combinational read, 1 = registered read.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = a same-cycle write is forwarded to the reads.
REQ-006 SHALL have parameter ZERO_REG, default 0: 1 = address 0 always reads 0 and ignores writes.
REQ-007 SHALL have a single clock and an asynchronous, active-low reset.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port writeEnable, input, 2 bits: per-write-port enable; bit i belongs to port i.
REQ-011 SHALL have port wrAddr, input, 2*NUM_ADDR_BITS bits: write addresses; port i in slice i.
REQ-012 SHALL have port wrData, input, 2*REG_WIDTH bits: write data; port i in slice i.
REQ-013 SHALL have port wrByteEn, input, 2*(REG_WIDTH/8) bits: per-byte write enables; port i in slice i.
REQ-014 SHALL have port rdAddr, input, NUM_RD_PORTS*NUM_ADDR_BITS bits: read addresses; port j in slice j.
REQ-015 SHALL have port rdData, output, NUM_RD_PORTS*REG_WIDTH bits: read data; port j in slice j.
REQ-016 SHALL have port wrCollision, output, 1 bit: registered flag; both write ports hit the same address in the previous cycle.

Function
REQ-017 SHALL write byte b of entry wrAddr[i] from wrData[i] at the rising edge when writeEnable[i]=1 and wrByteEn[i][b]=1.
REQ-018 SHALL leave bytes with a cleared byte enable unchanged.
REQ-019 SHALL write per byte when both ports target the same address in one cycle: port 1 wins bytes both ports enable; each port's other enabled bytes are written from that port.
REQ-020 SHALL set wrCollision to 1 for exactly the cycle after both ports are enabled to the same address, regardless of byte enables; otherwise wrCollision SHALL be 0.
REQ-021 SHALL, with READ_LATENCY=0, drive rdData[j] combinationally from entry rdAddr[j].
REQ-022 SHALL, with READ_LATENCY=1, register rdData[j] at the rising edge, giving 1-cycle latency from rdAddr[j].
REQ-023 SHALL, with BYPASS=1 and READ_LATENCY=0, return the merged post-write value per REQ-019 when a read address matches an enabled write address in the same cycle.
REQ-024 SHALL, with BYPASS=0 and READ_LATENCY=0, return the pre-write value under the same condition.
REQ-025 SHALL, with READ_LATENCY=1, capture the post-write value when BYPASS=1 and the pre-write value when BYPASS=0.
REQ-026 SHALL, with ZERO_REG=1, never change entry 0, return 0 on every read of address 0 (bypass included), and not assert wrCollision for address 0.
REQ-027 SHALL serve all read ports independently; any number of ports may read the same address.
REQ-028 SHALL use the full address range without wrap or range checking; address 2**NUM_ADDR_BITS-1 is a normal entry.

Reset
REQ-029 SHALL, while rst_n=0, clear every entry, wrCollision and any read-data registers to 0, asynchronously and without waiting for clk.
REQ-030 SHALL ignore writes in any cycle where rst_n is low at the rising edge, including a reset asserted mid-sequence.
REQ-031 SHALL resume normal operation at the first rising edge after rst_n is deasserted.

Verification
REQ-032 SHALL be covered: reset, then read all 64 addresses -> all 0x00000000 and wrCollision=0.
REQ-033 SHALL be covered: port0 writes 0x14578BB0 to addr 1 with byte enables 0xF; next cycle rdAddr[0]=1 -> 0x14578BB0; then a port0 write of 0xFFFFFFFF with byte enables 0x3 -> 0x1457FFFF.
REQ-034 SHALL be covered: in one cycle, port0 writes 0xAAAAAAAA with byte enables 0xF and port1 writes 0x55555555 with byte enables 0x5, both to addr 0x3F -> entry = 0xAA55AA55 and wrCollision=1 for one cycle.
REQ-035 SHALL be covered: with BYPASS=1 and latency 0, write 0xDDDDDDDD to addr 2 while rdAddr[1]=2 -> rdData[1]=0xDDDDDDDD in the same cycle; with BYPASS=0 -> the old value.
REQ-036 SHALL be covered: with ZERO_REG=1, write 0x88888888 to addr 0 -> reads of addr 0 return 0 and wrCollision stays 0 for a dual write to addr 0.
REQ-037 SHALL be covered: with READ_LATENCY=1, assert rst_n=0 between clock edges after writes -> rdData drops to 0 immediately and stored data is lost.
